// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that shares one load-enabled register between NREQ requesters.
// Issues at most one load every two cycles. Pointer-relative priority gives fair rotation.
//
// state | meaning
// IDLE  | waiting for an unlocked request; grant outputs low
// LOAD  | one-cycle grant: gnt/reg_ld/reg_d presented to the register
module reg_load_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  input  logic                    lock,
  output logic [NREQ-1:0]         gnt,
  output logic                    reg_ld,
  output logic [WIDTH-1:0]        reg_d,
  output logic                    busy,
  output logic [IDW-1:0]          last_id
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       ptr, ptr_nxt, win, last_id_nxt;
  logic [NREQ-1:0]      gnt_nxt;
  logic [WIDTH-1:0]     reg_d_nxt;

  // First set request at or above p, wrapping; scanned high-to-low so the nearest one wins.
  function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx_w;
    int             idx;
    w = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx   = (int'(p) + k) % NREQ;
      idx_w = idx[IDW-1:0];
      if (r[idx_w]) w = idx_w;
    end
    return w;
  endfunction

  always_comb win = pick(req, ptr);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = '0;
    reg_d_nxt   = reg_d;
    last_id_nxt = last_id;
    if (state == IDLE) begin
      if (!lock && (|req)) begin
        state_nxt   = LOAD;
        gnt_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << win;
        last_id_nxt = win;
        ptr_nxt     = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (win == IDW'(i)) reg_d_nxt = wdata[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      reg_d   <= '0;
      last_id <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      reg_d   <= reg_d_nxt;
      last_id <= last_id_nxt;
    end
  end

  assign reg_ld = |gnt;
  assign busy   = (state == LOAD);

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: directed scenarios then randomized requester traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_reg_load_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic                  lock = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic                  reg_ld;
  logic [WIDTH-1:0]      reg_d;
  logic                  busy;
  logic [IDW-1:0]        last_id;
  logic [WIDTH-1:0]      reg_q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  int             m_ptr  = 0;
  int             m_gnt  = -1;
  int             m_last = 0;
  bit             m_busy = 1'b0;
  logic [WIDTH-1:0] m_d  = '0;
  logic [WIDTH-1:0] m_q  = '0;

  reg_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .lock(lock),
    .gnt(gnt), .reg_ld(reg_ld), .reg_d(reg_d), .busy(busy), .last_id(last_id)
  );

  always #5 clk = ~clk;

  // The shared register downstream of the arbiter; its reset is tied inactive.
  always @(posedge clk) if (reg_ld) reg_q <= reg_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model one edge using the inputs as driven now, then compare after the edge.
  task automatic step();
    int w;
    if (m_gnt >= 0) m_q = m_d;
    if (!rst_n) begin
      m_ptr = 0; m_gnt = -1; m_last = 0; m_busy = 1'b0; m_d = '0;
    end else if (m_busy) begin
      m_busy = 1'b0; m_gnt = -1;
    end else if (!lock && req != '0) begin
      w = -1;
      for (int k = 0; k < NREQ && w < 0; k++)
        if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      m_gnt  = w;
      m_d    = wdata[w*WIDTH +: WIDTH];
      m_last = w;
      m_ptr  = (w + 1) % NREQ;
      m_busy = 1'b1;
    end else begin
      m_gnt = -1;
    end
    @(posedge clk);
    #1;
    chk("gnt",     32'(gnt),     (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
    chk("reg_ld",  32'(reg_ld),  (m_gnt < 0) ? 32'd0 : 32'd1);
    chk("busy",    32'(busy),    32'(m_busy));
    chk("last_id", 32'(last_id), 32'(m_last));
    chk("reg_d",   32'(reg_d),   32'(m_d));
    chk("reg_q",   32'(reg_q),   32'(m_q));
  endtask

  initial begin
    // Reset with all requests pending
    rst_n = 1'b0; req = 4'b1111; wdata = 16'h4321;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_last", 32'(last_id), 32'd0);
    rst_n = 1'b1;

    // Full rotation with every requester holding its request
    step();
    chk("rot_first", 32'(gnt), 32'h1);
    for (int i = 0; i < 8; i++) step();
    chk("rot_wrap", 32'(gnt), 32'h1);
    chk("rot_wrap_d", 32'(reg_d), 32'h1);

    // Priority wrap: grant 3, then 0 and 3 compete
    req = 4'b1000;
    step(); step();
    chk("wrap_g3", 32'(gnt), 32'h8);
    req = 4'b1001;
    step(); step();
    chk("wrap_g0", 32'(gnt), 32'h1);
    req = 4'b1000;
    step(); step();
    chk("wrap_g3b", 32'(gnt), 32'h8);

    // Single requester holding its request
    req = 4'b0100; wdata = 16'h0A00;
    step(); step();
    chk("single_g", 32'(gnt), 32'h4);
    step();
    chk("single_q", 32'(reg_q), 32'hA);
    for (int i = 0; i < 5; i++) step();
    chk("single_last", 32'(last_id), 32'd2);

    // Lock blocks grants; raising it during LOAD lets the load finish
    req = '0;
    step();
    lock = 1'b1; req = 4'b0010; wdata = 16'h00B0;
    for (int i = 0; i < 5; i++) step();
    chk("lock_nog", 32'(gnt), 32'd0);
    lock = 1'b0;
    step();
    chk("lock_rel", 32'(gnt), 32'h2);
    lock = 1'b1;
    step();
    chk("lock_q", 32'(reg_q), 32'hB);
    step(); step();

    // Reset during the grant cycle
    lock = 1'b0;
    step();
    chk("mid_ld", 32'(reg_ld), 32'd1);
    rst_n = 1'b0; req = 4'b1010;
    step();
    chk("mid_rst", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_ptr0", 32'(gnt), 32'h2);
    req = '0;
    step();

    // Random traffic following the handshake: requests drop at the end of their grant cycle
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          if ($urandom_range(2) == 0) req[i] = 1'b1;
        end
      end
      lock = ($urandom_range(5) == 0);
      step();
      if (m_gnt >= 0) req[m_gnt] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
